timer_dev: RTL and testbench

Memory-mapped countdown timer on the CPU's data-side bus, downstream of the multicycle core's data-memory address/write-data path. The core reaches it via word-addressed loads/stores decoded from its ALU address register. The timer counts down a software-programmed preset and raises an interrupt request toward the core on expiry, in one-shot or auto-reload mode.

---
 rtl/timer_dev_pkg.sv | 32 +++
 rtl/timer_dev.sv | 187 ++++++++++++++++++
 tb/tb_timer_dev.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg: shared definitions for the memory-mapped countdown timer.
// FSM state encoding, register word offsets, CTRL bit positions and MODE codes.
package timer_dev_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   // Word offsets (byte address bits [3:2])
   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   // CTRL field positions
   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM_BIT   = 3;

   // MODE encodings; 1x behaves as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   function automatic logic is_reload(input logic [1:0] mode);
      return (mode == MODE_RELOAD);
   endfunction

endpackage

// File: rtl/timer_dev.sv
// timer_dev: 32-bit countdown timer with CTRL/PRESET/COUNT registers and an
// interrupt request. Optional feature macro: TIMER_AUTORELOAD_EN enables
// MODE 01 auto-reload; without it MODE reads 00 and every expiry is one-shot.
// Register file and FSM live together because EN and pending are updated by
// both software writes and the FSM with a fixed priority.
module timer_dev
   import timer_dev_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   state_t      state_reg;
   state_t      state_next;

   logic        ctrl_en_reg;
   logic        ctrl_im_reg;
   logic [1:0]  ctrl_mode;
   logic [31:0] preset_reg;
   logic [31:0] count_reg;
   logic        pending_reg;

   logic        wr_ctrl;
   logic        wr_preset;
   logic        reload_active;

   // FSM command outputs
   logic        load_count;
   logic        dec_count;
   logic        zero_count;
   logic        set_pending;
   logic        fsm_clr_en;

   assign wr_ctrl   = we && (addr == OFF_CTRL);
   assign wr_preset = we && (addr == OFF_PRESET);

`ifdef TIMER_AUTORELOAD_EN
   logic [1:0] ctrl_mode_reg;

   // MODE field is stored as written; only 01 selects reload
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_mode_reg <= MODE_ONESHOT;
      end else if (wr_ctrl) begin
         ctrl_mode_reg <= wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
      end
   end

   assign ctrl_mode     = ctrl_mode_reg;
   assign reload_active = is_reload(ctrl_mode_reg);
`else
   assign ctrl_mode     = MODE_ONESHOT;
   assign reload_active = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; EN is sampled from the register, so a cleared EN is
   // honoured one cycle after the write that cleared it
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (ctrl_en_reg) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            state_next = ctrl_en_reg ? ST_CNT : ST_IDLE;
         end
         ST_CNT: begin
            if (!ctrl_en_reg) begin
               state_next = ST_IDLE;
            end else if (count_reg <= 32'd1) begin
               state_next = ST_INT;
            end
         end
         ST_INT: begin
            state_next = (ctrl_en_reg && reload_active) ? ST_LOAD : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM command decode: counter load/decrement, expiry, one-shot EN clear
   always_comb begin
      load_count  = 1'b0;
      dec_count   = 1'b0;
      zero_count  = 1'b0;
      set_pending = 1'b0;
      fsm_clr_en  = 1'b0;
      case (state_reg)
         ST_LOAD: begin
            load_count = ctrl_en_reg;
         end
         ST_CNT: begin
            if (ctrl_en_reg) begin
               if (count_reg > 32'd1) begin
                  dec_count = 1'b1;
               end else begin
                  // COUNT of 1 drops to 0; COUNT of 0 stays (no wrap)
                  zero_count  = 1'b1;
                  set_pending = 1'b1;
               end
            end
         end
         ST_INT: begin
            fsm_clr_en = ctrl_en_reg && !reload_active;
         end
         default: ;
      endcase
   end

   // CTRL.EN / CTRL.IM; a software write beats the FSM's one-shot clear
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_en_reg <= 1'b0;
         ctrl_im_reg <= 1'b0;
      end else if (wr_ctrl) begin
         ctrl_en_reg <= wdata[CTRL_EN_BIT];
         ctrl_im_reg <= wdata[CTRL_IM_BIT];
      end else if (fsm_clr_en) begin
         ctrl_en_reg <= 1'b0;
      end
   end

   // PRESET register; only copied into COUNT in LOAD
   always_ff @(posedge clk) begin
      if (rst) begin
         preset_reg <= '0;
      end else if (wr_preset) begin
         preset_reg <= wdata;
      end
   end

   // COUNT register, driven only by the FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load_count) begin
         count_reg <= preset_reg;
      end else if (dec_count) begin
         count_reg <= count_reg - 32'd1;
      end else if (zero_count) begin
         count_reg <= '0;
      end
   end

   // Sticky pending flag; a new expiry wins over a same-edge clearing write
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_reg <= 1'b0;
      end else if (set_pending) begin
         pending_reg <= 1'b1;
      end else if (wr_ctrl || wr_preset) begin
         pending_reg <= 1'b0;
      end
   end

   // Combinational read mux
   always_comb begin
      rdata = '0;
      case (addr)
         OFF_CTRL: begin
            rdata[CTRL_EN_BIT]                 = ctrl_en_reg;
            rdata[CTRL_MODE_MSB:CTRL_MODE_LSB] = ctrl_mode;
            rdata[CTRL_IM_BIT]                 = ctrl_im_reg;
         end
         OFF_PRESET: rdata = preset_reg;
         OFF_COUNT:  rdata = count_reg;
         default:    rdata = '0;
      endcase
   end

   assign irq = pending_reg && ctrl_im_reg;

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: self-checking bench for timer_dev. Expected values come from a
// schedule model: expiry edges, COUNT per cycle and EN are computed from the
// preset value and the cycle index since the enabling CTRL write.
module tb_timer_dev;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef TIMER_AUTORELOAD_EN
   localparam bit HAS_RELOAD = 1'b1;
`else
   localparam bit HAS_RELOAD = 1'b0;
`endif

   always #5 clk = ~clk;

   timer_dev dut (
      .clk   (clk),
      .rst   (rst),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   // ---------------- reference model ----------------
   // Cycles from the first load to expiry (a zero preset still takes one).
   function automatic int dly(input int n);
      return (n == 0) ? 1 : n;
   endfunction

   // COUNT after edge E+k, where E is the enabling CTRL write edge.
   function automatic int exp_count(input int n, input bit reload, input int k, input int prev);
      int j;
      int p;
      if (k < 2) return prev;
      j = k - 2;
      p = dly(n) + 2;
      if (reload) j = j % p;
      if (reload && j > dly(n)) return 0;
      return (j >= n) ? 0 : n - j;
   endfunction

   // pending after edge E+k; a CTRL rewrite at edge wk (0 = none) clears
   // every expiry strictly before wk.
   function automatic bit exp_pending(input int n, input bit reload, input int k, input int wk);
      int first;
      int p;
      int latest;
      int clr;
      first = 2 + dly(n);
      p     = dly(n) + 2;
      if (k < first) return 1'b0;
      latest = reload ? first + ((k - first) / p) * p : first;
      clr    = (wk != 0 && k >= wk) ? wk : 0;
      return latest >= clr;
   endfunction

   function automatic bit exp_en(input int n, input bit reload, input int k);
      if (reload) return 1'b1;
      return k <= 2 + dly(n);
   endfunction

   // ---------------- bus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      addr = a;
      #1;
      v = rdata;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      logic [31:0] v;
      for (int a = 0; a < 4; a++) begin
         rd(a[1:0], v);
         n_checks++;
         if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL %s rdata[%0d] got %h expected 0", tag, a, v);
         end
      end
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL %s irq got %b expected 0", tag, irq);
      end
   endtask

   // Program PRESET=n, write CTRL, then check COUNT/CTRL/irq every cycle.
   // wk>0 rewrites the same CTRL value at edge E+wk.
   task automatic run_timer(input int n, input logic [1:0] mode, input bit im,
                            input int cycles, input int wk, input int prev,
                            input string tag);
      logic [31:0] ctrl;
      logic [31:0] ctrl_rd_exp;
      logic [1:0]  mode_rd;
      logic [31:0] v;
      bit          reload;
      bit          irq_exp;
      reload  = HAS_RELOAD && (mode == 2'b01);
      mode_rd = HAS_RELOAD ? mode : 2'b00;
      ctrl    = {28'h0, im, mode, 1'b1};
      wr(2'd1, n);
      wr(2'd0, ctrl);
      for (int k = 0; k <= cycles; k++) begin
         if (k > 0) begin
            if (wk != 0 && k == wk) wr(2'd0, ctrl);
            else tick();
         end
         rd(2'd2, v);
         n_checks++;
         if (v !== exp_count(n, reload, k, prev)) begin
            n_fail++;
            $display("FAIL %s count n=%0d k=%0d got %0d expected %0d",
                     tag, n, k, v, exp_count(n, reload, k, prev));
         end
         ctrl_rd_exp = {28'h0, im, mode_rd, exp_en(n, reload, k)};
         rd(2'd0, v);
         n_checks++;
         if (v !== ctrl_rd_exp) begin
            n_fail++;
            $display("FAIL %s ctrl n=%0d k=%0d got %h expected %h", tag, n, k, v, ctrl_rd_exp);
         end
         irq_exp = exp_pending(n, reload, k, wk) && im;
         n_checks++;
         if (irq !== irq_exp) begin
            n_fail++;
            $display("FAIL %s irq n=%0d k=%0d got %b expected %b", tag, n, k, irq, irq_exp);
         end
      end
      $display("txn %s preset=%0d mode=%0d im=%0d wk=%0d cycles=%0d", tag, n, mode, im, wk, cycles);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      check_all_zero("reset");
      $display("txn reset: offsets 0-3 and irq checked");
   endtask

   task automatic test_oneshot();
      do_reset();
      run_timer(5, 2'b00, 1'b1, 14, 0, 0, "oneshot");
   endtask

   task automatic test_autoreload();
      int wk;
      do_reset();
      // With reload, rewrite CTRL right after the first expiry to clear irq
      // for one period; without it, rewrite on the expiry edge (set wins).
      wk = HAS_RELOAD ? 6 : 5;
      run_timer(3, 2'b01, 1'b1, 22, wk, 0, "autoreload");
   endtask

   task automatic test_zero_preset();
      do_reset();
      run_timer(0, 2'b00, 1'b1, 8, 0, 0, "zero_preset");
   endtask

   task automatic test_midcount();
      logic [31:0] v;
      do_reset();
      wr(2'd1, 32'd150);
      wr(2'd0, 32'h1);
      for (int k = 1; k <= 52; k++) begin
         if (k == 10) begin
            wr(2'd1, 32'd7);
            rd(2'd2, v);
            n_checks++;
            if (v !== 32'd142) begin
               n_fail++;
               $display("FAIL midcount count_after_preset_write got %0d expected 142", v);
            end
            rd(2'd1, v);
            n_checks++;
            if (v !== 32'd7) begin
               n_fail++;
               $display("FAIL midcount preset_readback got %0d expected 7", v);
            end
         end else begin
            tick();
         end
      end
      rd(2'd2, v);
      n_checks++;
      if (v !== 32'd100) begin
         n_fail++;
         $display("FAIL midcount count_before_stop got %0d expected 100", v);
      end
      wr(2'd0, 32'h0);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         rd(2'd2, v);
         n_checks++;
         if (v !== 32'd99) begin
            n_fail++;
            $display("FAIL midcount frozen_count i=%0d got %0d expected 99", i, v);
         end
      end
      rd(2'd0, v);
      n_checks++;
      if (v !== 32'h0) begin
         n_fail++;
         $display("FAIL midcount ctrl got %h expected 0", v);
      end
      $display("txn midcount: stopped at 99, preset write ignored by count");
   endtask

   task automatic test_im0();
      logic [31:0] v;
      do_reset();
      run_timer(4, 2'b00, 1'b0, 10, 0, 0, "im0");
      wr(2'd0, 32'h8);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         n_checks++;
         if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL im0 irq_after_ctrl_write i=%0d got %b expected 0", i, irq);
         end
      end
      rd(2'd0, v);
      n_checks++;
      if (v !== 32'h8) begin
         n_fail++;
         $display("FAIL im0 ctrl got %h expected 8", v);
      end
      $display("txn im0: ctrl write cleared pending");
   endtask

   task automatic test_rst_midcount();
      logic [31:0] v;
      do_reset();
      wr(2'd1, 32'd80);
      wr(2'd0, 32'h9);
      for (int k = 1; k <= 32; k++) tick();
      rd(2'd2, v);
      n_checks++;
      if (v !== 32'd50) begin
         n_fail++;
         $display("FAIL rst_midcount count_before_rst got %0d expected 50", v);
      end
      do_reset();
      check_all_zero("rst_midcount");
      tick();
      check_all_zero("rst_midcount_hold");
      $display("txn rst_midcount: reset at count 50");
   endtask

   task automatic test_random();
      int          n;
      int          wk;
      logic [1:0]  mode;
      bit          im;
      for (int it = 0; it < 10; it++) begin
         n    = $urandom_range(0, 10);
         mode = 2'($urandom_range(0, 3));
         im   = 1'($urandom_range(0, 1));
         wk   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 + dly(n)) : 0;
         do_reset();
         check_all_zero("rand_reset");
         run_timer(n, mode, im, 3 * (n + 2) + 4, wk, 0, "random");
      end
   endtask

   initial begin
      rst   = 1'b1;
      we    = 1'b0;
      addr  = 2'd0;
      wdata = 32'h0;
      test_reset();
      test_oneshot();
      test_autoreload();
      test_zero_preset();
      test_midcount();
      test_im0();
      test_rst_midcount();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
